// File: rtl/bit_scan_32.sv
// bit_scan_32
//
// Sequential set-bit scanner for 32-bit flag and mask words. A word is
// latched on an accepted start, and the index of each set bit is then
// presented one at a time over a valid/ready handshake. The scan ends with
// a one-cycle done pulse, with the OR-reduction and the population count
// of the word available alongside it.
//
// Optional build macro:
//   BIT_SCAN_MSB_FIRST_EN - when defined, indices are emitted from the
//                           highest set bit down. When undefined (the
//                           default), they are emitted from the lowest up.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request a scan of A (sampled only while idle)
//   A          in   word to scan, captured on an accepted start
//   busy       out  high while scanning and during the done cycle
//   idx_valid  out  idx holds a set-bit index
//   idx        out  current set-bit index, 0 when idx_valid is low
//   idx_ready  in   consumer accepts idx
//   done       out  one-cycle pulse at scan end
//   any        out  OR-reduction of the captured word
//   count      out  number of indices emitted since the last start

module bit_scan_32 #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  A,
    output logic              busy,
    output logic              idx_valid,
    output logic [IDXW-1:0]   idx,
    input  logic              idx_ready,
    output logic              done,
    output logic              any,
    output logic [IDXW:0]     count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   s;
    logic [IDXW-1:0]    enc;
    logic [WIDTH-1:0]   s_cleared;

    // Priority encoder over the shadow word. The loop direction decides
    // which set bit wins: the last matching iteration is the one kept.
    always_comb begin
        enc = '0;
`ifdef BIT_SCAN_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i]) enc = IDXW'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (s[i]) enc = IDXW'(i);
        end
`endif
    end

    // Shadow word with the currently presented bit removed; used both as
    // the next value on a handshake and to detect the final index.
    assign s_cleared = s & ~(WIDTH'(1) << enc);

    // idx_valid and idx depend only on registered state, so idx_ready has
    // no combinational path to them.
    assign idx_valid = (state == SCAN);
    assign idx       = idx_valid ? enc : '0;

    // Scan controller. busy and done are registered alongside the state so
    // they change on the same edge as the state transition they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            any   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        s     <= A;
                        any   <= |A;
                        count <= '0;
                        busy  <= 1'b1;
                        if (A != '0) begin
                            state <= SCAN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (idx_ready) begin
                        s     <= s_cleared;
                        count <= count + (IDXW+1)'(1);
                        if (s_cleared == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_scan_32.sv
// tb_bit_scan_32
//
// Directed bench for bit_scan_32. Each scenario lives in its own task and
// compares DUT outputs against hand-computed values on the falling edge,
// away from the active rising edge. Inputs change on the falling edge.
// Expected index order follows BIT_SCAN_MSB_FIRST_EN when it is defined.

module tb_bit_scan_32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic        busy;
    logic        idx_valid;
    logic [4:0]  idx;
    logic        idx_ready;
    logic        done;
    logic        any;
    logic [5:0]  count;

    int n_checks;
    int n_fail;

    bit_scan_32 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .busy      (busy),
        .idx_valid (idx_valid),
        .idx       (idx),
        .idx_ready (idx_ready),
        .done      (done),
        .any       (any),
        .count     (count)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle and return on the first falling edge after
    // the accepting rising edge (the first cycle after acceptance).
    task automatic do_start(input logic [31:0] word);
        @(negedge clk);
        start = 1'b1;
        A     = word;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({idx_valid, idx, done, busy, any, count} !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%0b idx=%0d done=%0b busy=%0b any=%0b count=%0d, want all 0",
                     idx_valid, idx, done, busy, any, count);
        end
    endtask

    task automatic test_zero_word();
        idx_ready = 1'b1;
        do_start(32'h0000_0000);
        n_checks++;
        if ({done, busy, any, count, idx_valid} !== {1'b1, 1'b1, 1'b0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL zero_done: got done=%0b busy=%0b any=%0b count=%0d valid=%0b, want 1 1 0 0 0",
                     done, busy, any, count, idx_valid);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, idx_valid} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL zero_idle: got done=%0b busy=%0b valid=%0b, want 0 0 0", done, busy, idx_valid);
        end
    endtask

    task automatic test_sparse_word();
        logic [4:0] first, second;
`ifdef BIT_SCAN_MSB_FIRST_EN
        first = 5'd31; second = 5'd0;
`else
        first = 5'd0;  second = 5'd31;
`endif
        idx_ready = 1'b1;
        do_start(32'h8000_0001);
        n_checks++;
        if ({idx_valid, idx, count, any, busy} !== {1'b1, first, 6'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL sparse_first: got valid=%0b idx=%0d count=%0d any=%0b busy=%0b, want 1 %0d 0 1 1",
                     idx_valid, idx, count, any, busy, first);
        end
        @(negedge clk);
        n_checks++;
        if ({idx_valid, idx, count} !== {1'b1, second, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL sparse_second: got valid=%0b idx=%0d count=%0d, want 1 %0d 1",
                     idx_valid, idx, count, second);
        end
        @(negedge clk);
        n_checks++;
        if ({done, idx_valid, idx, count, any} !== {1'b1, 1'b0, 5'd0, 6'd2, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL sparse_done: got done=%0b valid=%0b idx=%0d count=%0d any=%0b, want 1 0 0 2 1",
                     done, idx_valid, idx, count, any);
        end
        @(negedge clk);
        n_checks++;
        if ({done, busy, count, any} !== {1'b0, 1'b0, 6'd2, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL sparse_hold: got done=%0b busy=%0b count=%0d any=%0b, want 0 0 2 1",
                     done, busy, count, any);
        end
    endtask

    task automatic test_full_word();
        logic [4:0] exp_idx;
        idx_ready = 1'b1;
        do_start(32'hFFFF_FFFF);
        for (int k = 0; k < 32; k++) begin
`ifdef BIT_SCAN_MSB_FIRST_EN
            exp_idx = 5'(31 - k);
`else
            exp_idx = 5'(k);
`endif
            n_checks++;
            if ({idx_valid, idx, count} !== {1'b1, exp_idx, 6'(k)}) begin
                n_fail++;
                $display("[TB] FAIL full_idx[%0d]: got valid=%0b idx=%0d count=%0d, want 1 %0d %0d",
                         k, idx_valid, idx, count, exp_idx, k);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({done, idx_valid, count, any} !== {1'b1, 1'b0, 6'd32, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL full_done: got done=%0b valid=%0b count=%0d any=%0b, want 1 0 32 1",
                     done, idx_valid, count, any);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [4:0] first, second;
`ifdef BIT_SCAN_MSB_FIRST_EN
        first = 5'd4; second = 5'd2;
`else
        first = 5'd2; second = 5'd4;
`endif
        idx_ready = 1'b0;
        do_start(32'h0000_0014);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if ({idx_valid, idx, count, done} !== {1'b1, first, 6'd0, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL bp_stall[%0d]: got valid=%0b idx=%0d count=%0d done=%0b, want 1 %0d 0 0",
                         c, idx_valid, idx, count, done, first);
            end
            if (c < 2) @(negedge clk);
        end
        idx_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({idx_valid, idx, count} !== {1'b1, second, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL bp_second: got valid=%0b idx=%0d count=%0d, want 1 %0d 1",
                     idx_valid, idx, count, second);
        end
        @(negedge clk);
        n_checks++;
        if ({done, count} !== {1'b1, 6'd2}) begin
            n_fail++;
            $display("[TB] FAIL bp_done: got done=%0b count=%0d, want 1 2", done, count);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        logic [4:0] first, second;
`ifdef BIT_SCAN_MSB_FIRST_EN
        first = 5'd9; second = 5'd8;
`else
        first = 5'd8; second = 5'd9;
`endif
        idx_ready = 1'b1;
        do_start(32'h0000_0300);
        start = 1'b1;
        A     = 32'h0000_0001;
        n_checks++;
        if ({idx_valid, idx} !== {1'b1, first}) begin
            n_fail++;
            $display("[TB] FAIL intf_first: got valid=%0b idx=%0d, want 1 %0d", idx_valid, idx, first);
        end
        @(negedge clk);
        n_checks++;
        if ({idx_valid, idx, count} !== {1'b1, second, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL intf_second: got valid=%0b idx=%0d count=%0d, want 1 %0d 1",
                     idx_valid, idx, count, second);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({done, idx_valid, count} !== {1'b1, 1'b0, 6'd2}) begin
            n_fail++;
            $display("[TB] FAIL intf_done: got done=%0b valid=%0b count=%0d, want 1 0 2", done, idx_valid, count);
        end
        @(negedge clk);
        n_checks++;
        if ({busy, idx_valid, done, count} !== {1'b0, 1'b0, 1'b0, 6'd2}) begin
            n_fail++;
            $display("[TB] FAIL intf_idle: got busy=%0b valid=%0b done=%0b count=%0d, want 0 0 0 2",
                     busy, idx_valid, done, count);
        end
    endtask

    task automatic test_reset_mid_scan();
        idx_ready = 1'b1;
        do_start(32'h0000_0300);
        @(negedge clk);
        n_checks++;
        if ({idx_valid, count} !== {1'b1, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL rstmid_pre: got valid=%0b count=%0d, want 1 1", idx_valid, count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({idx_valid, idx, done, busy, any, count} !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_clear: got valid=%0b idx=%0d done=%0b busy=%0b any=%0b count=%0d, want all 0",
                     idx_valid, idx, done, busy, any, count);
        end
        @(negedge clk);
        n_checks++;
        if ({idx_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL rstmid_idle: got valid=%0b busy=%0b done=%0b, want 0 0 0", idx_valid, busy, done);
        end
    endtask

    task automatic test_back_to_back();
        idx_ready = 1'b1;
        do_start(32'h0000_0001);
        @(negedge clk);
        // DONE cycle: a start here must be ignored
        start = 1'b1;
        A     = 32'h0000_0002;
        n_checks++;
        if ({done, count} !== {1'b1, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL b2b_done: got done=%0b count=%0d, want 1 1", done, count);
        end
        @(negedge clk);
        // IDLE cycle: start held, now with a different word
        A = 32'h0000_0004;
        n_checks++;
        if ({busy, idx_valid, count} !== {1'b0, 1'b0, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL b2b_idle: got busy=%0b valid=%0b count=%0d, want 0 0 1", busy, idx_valid, count);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({idx_valid, idx, count, busy} !== {1'b1, 5'd2, 6'd0, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL b2b_second: got valid=%0b idx=%0d count=%0d busy=%0b, want 1 2 0 1",
                     idx_valid, idx, count, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({done, count} !== {1'b1, 6'd1}) begin
            n_fail++;
            $display("[TB] FAIL b2b_end: got done=%0b count=%0d, want 1 1", done, count);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        A         = '0;
        idx_ready = 1'b0;

        test_reset();
        test_zero_word();
        test_sparse_word();
        test_full_word();
        test_backpressure();
        test_start_ignored();
        test_reset_mid_scan();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
